// File: rtl/structs_pkg.sv
// Shared fetch-stage types, opcode constants and immediate helpers.
package structs_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_DEF-1:0] pc;
        logic                pred_taken;
    } fetch_entry_t;

    // Conditional-branch offset, 13 bits including the implicit zero LSB.
    function automatic logic [12:0] br_imm(input logic [31:0] i);
        return {i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // JAL offset, 21 bits including the implicit zero LSB.
    function automatic logic [20:0] jal_imm(input logic [31:0] i);
        return {i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with flush; count-based full/empty, no bypass.
module fetch_queue
    import structs_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_flush,
    input  T     i_wdata,
    output T     o_rdata,
    output logic o_full,
    output logic o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    // Flush wins over both ports; a full queue refuses pushes even when popping.
    assign w_do_push = i_push & ~o_full  & ~i_flush;
    assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;
    assign o_rdata   = r_mem[r_head];

    // Entry storage is intentionally not reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail] <= i_wdata;
    end

    // Pointer and occupancy bookkeeping; pointers wrap by width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + 1'b1;
            if (w_do_pop)  r_head <= r_head + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC generator with branch/JAL pre-decode feeding a fetch queue toward decode.
module fetch_unit
    import structs_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            pred_taken,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fq_valid,
    input  logic            fq_ready,
    output logic [31:0]     fq_instr,
    output logic [XLEN-1:0] fq_pc,
    output logic            fq_pred_taken
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
    } entry_t;

    logic [XLEN-1:0] r_pc;

    logic            w_is_br;
    logic            w_is_jal;
    logic            w_eff_taken;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_next_pc;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    entry_t          w_wentry;
    entry_t          w_head;

    logic [12:0] w_br_imm;
    logic [20:0] w_jal_imm;

    assign w_br_imm    = br_imm(imem_rdata);
    assign w_jal_imm   = jal_imm(imem_rdata);
    assign w_is_br     = (imem_rdata[6:0] == OP_BRANCH);
    assign w_is_jal    = (imem_rdata[6:0] == OP_JAL);
    // JAL is always taken; branches follow the predictor; JALR is treated as sequential.
    assign w_eff_taken = (w_is_br & pred_taken) | w_is_jal;
    assign w_imm       = w_is_jal ? {{(XLEN-21){w_jal_imm[20]}}, w_jal_imm}
                                  : {{(XLEN-13){w_br_imm[12]}}, w_br_imm};
    assign w_next_pc   = w_eff_taken ? (r_pc + w_imm) : (r_pc + XLEN'(4));
    assign w_push      = ~redirect_valid & ~w_full;
    assign w_wentry    = '{instr: imem_rdata, pc: r_pc, pred_taken: w_eff_taken};

    // PC register: redirect overrides, otherwise advance only when the word is enqueued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            r_pc <= RESET_PC;
        else if (redirect_valid) r_pc <= redirect_pc;
        else if (w_push)         r_pc <= w_next_pc;
    end

    fetch_queue #(
        .T     (entry_t),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (fq_ready),
        .i_flush (redirect_valid),
        .i_wdata (w_wentry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_addr     = r_pc;
    assign fq_valid      = ~w_empty;
    assign fq_instr      = w_head.instr;
    assign fq_pc         = w_head.pc;
    assign fq_pred_taken = w_head.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fq_valid;
    logic        fq_ready;
    logic [31:0] fq_instr;
    logic [31:0] fq_pc;
    logic        fq_pred_taken;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pred_taken     (pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fq_valid       (fq_valid),
        .fq_ready       (fq_ready),
        .fq_instr       (fq_instr),
        .fq_pc          (fq_pc),
        .fq_pred_taken  (fq_pred_taken)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDI = 32'h00000013;
    localparam logic [31:0] BEQ  = 32'h02000063;
    localparam logic [31:0] JAL  = 32'hFF9FF06F;
    localparam logic [31:0] JALR = 32'h00008067;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pt;
    } ment_t;

    ment_t       q[$];
    logic [31:0] mpc;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offset decoded from the instruction fields with plain integer weights.
    function automatic int m_offset(input logic [31:0] i, input bit is_jal);
        if (is_jal)
            return (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + (i[20] ? 2048 : 0)
                   + int'(i[30:21]) * 2;
        return (i[31] ? -4096 : 0) + (i[7] ? 2048 : 0) + int'(i[30:25]) * 32
               + int'(i[11:8]) * 2;
    endfunction

    task automatic model_step(input logic [31:0] rd, input logic pt, input logic rv,
                              input logic [31:0] rpc, input logic rdy);
        bit    br, jl, take, full, pop;
        ment_t e;
        if (rv) begin
            q.delete();
            mpc = rpc;
            return;
        end
        full = (q.size() == 4);
        pop  = (q.size() > 0) && rdy;
        if (pop) void'(q.pop_front());
        if (!full) begin
            br   = (rd[6:0] == 7'b1100011);
            jl   = (rd[6:0] == 7'b1101111);
            take = (br && pt) || jl;
            e.instr = rd; e.pc = mpc; e.pt = take;
            q.push_back(e);
            mpc = take ? mpc + 32'(m_offset(rd, jl)) : mpc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, imem_addr, mpc);
        chk({tag, ".valid"}, 32'(fq_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk({tag, ".pc"}, fq_pc, q[0].pc);
            chk({tag, ".instr"}, fq_instr, q[0].instr);
            chk({tag, ".pt"}, 32'(fq_pred_taken), 32'(q[0].pt));
        end
    endtask

    // Drive one cycle just after a falling edge, advance the model, check at the next falling edge.
    task automatic drv(input string tag, input logic [31:0] rd, input logic pt, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
        imem_rdata = rd; pred_taken = pt; redirect_valid = rv; redirect_pc = rpc; fq_ready = rdy;
        model_step(rd, pt, rv, rpc, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  ops [4];
        ops[0] = 7'b1100011; ops[1] = 7'b1101111; ops[2] = 7'b1100111; ops[3] = 7'b0010011;

        reset_n = 1'b0; imem_rdata = ADDI; pred_taken = 0; redirect_valid = 0;
        redirect_pc = 0; fq_ready = 0;
        mpc = 32'h0;
        repeat (2) @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;

        // Sequential stream
        drv("seq0", ADDI, 0, 0, 0, 1);
        chk("seq0.addr4", imem_addr, 32'h4);
        drv("seq1", ADDI, 0, 0, 0, 1);
        chk("seq1.addr8", imem_addr, 32'h8);
        chk("seq1.fqpc4", fq_pc, 32'h4);

        // Branch taken / not taken at 0x10
        drv("br.rd", ADDI, 0, 1, 32'h10, 1);
        drv("br.t", BEQ, 1, 0, 0, 1);
        chk("br.t.addr", imem_addr, 32'h30);
        chk("br.t.pt", 32'(fq_pred_taken), 32'h1);
        drv("br.rd2", ADDI, 0, 1, 32'h10, 1);
        drv("br.nt", BEQ, 0, 0, 0, 1);
        chk("br.nt.addr", imem_addr, 32'h14);

        // JAL backward and JALR at 0x40
        drv("jal.rd", ADDI, 0, 1, 32'h40, 1);
        drv("jal", JAL, 0, 0, 0, 1);
        chk("jal.addr", imem_addr, 32'h38);
        chk("jal.pt", 32'(fq_pred_taken), 32'h1);
        drv("jalr.rd", ADDI, 0, 1, 32'h40, 1);
        drv("jalr", JALR, 1, 0, 0, 1);
        chk("jalr.addr", imem_addr, 32'h44);
        chk("jalr.pt", 32'(fq_pred_taken), 32'h0);

        // Fill, stall, single pop, drain in order
        drv("full.rd", ADDI, 0, 1, 32'h0, 0);
        for (int i = 0; i < 6; i++) drv("full", ADDI, 0, 0, 0, 0);
        chk("full.hold", imem_addr, 32'h10);
        chk("full.head0", fq_pc, 32'h0);
        drv("full.pop", ADDI, 0, 0, 0, 1);
        chk("full.nopush", imem_addr, 32'h10);
        chk("full.head4", fq_pc, 32'h4);
        drv("full.resume", ADDI, 0, 0, 0, 0);
        chk("full.resume.addr", imem_addr, 32'h14);
        drv("drain", ADDI, 0, 0, 0, 1);
        chk("drain.8", fq_pc, 32'h8);
        drv("drain", ADDI, 0, 0, 0, 1);
        chk("drain.c", fq_pc, 32'hC);
        drv("drain", ADDI, 0, 0, 0, 1);
        chk("drain.10", fq_pc, 32'h10);

        // Redirect with 3 queued and a concurrent pop request
        drv("rdr.rd", ADDI, 0, 1, 32'h0, 0);
        for (int i = 0; i < 3; i++) drv("rdr.fill", ADDI, 0, 0, 0, 0);
        drv("rdr", BEQ, 1, 1, 32'h200, 1);
        chk("rdr.valid", 32'(fq_valid), 32'h0);
        chk("rdr.addr", imem_addr, 32'h200);
        drv("rdr.first", ADDI, 0, 0, 0, 0);
        chk("rdr.fqpc", fq_pc, 32'h200);

        // Randomized traffic, including wrap near the top of the address space
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 3)];
            if ($urandom_range(0, 19) == 0)
                drv("rnd", r, 1'($urandom), 1, (n % 3 == 0) ? 32'hFFFFFFF8 : ($urandom & ~32'h3), 1'($urandom));
            else
                drv("rnd", r, 1'($urandom), 0, 0, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges with 2 queued
        drv("ar.rd", ADDI, 0, 1, 32'h80, 0);
        drv("ar.fill", ADDI, 0, 0, 0, 0);
        drv("ar.fill", ADDI, 0, 0, 0, 0);
        chk("ar.pre", 32'(fq_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar.valid", 32'(fq_valid), 32'h0);
        chk("ar.addr", imem_addr, 32'h0);
        q.delete();
        mpc = 32'h0;
        @(negedge clk);
        check_all("ar.held");
        reset_n = 1'b1;
        drv("ar.after", ADDI, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
